clkdiv_bank: RTL and testbench
==============================

CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of each channel counter and divisor.
REQ-003 The block SHALL have parameter DIV_INIT, a packed vector of NCH*CNT_W bits (channel 0 in the LSBs), default {50000000, 200000, 50000000, 25000000}, giving each channel's reset-time divisor.
REQ-004 The block SHALL have port masterClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset; it is synchronous and active-high.
REQ-006 The block SHALL have port ch_en, input, NCH bits: per-channel run enable.
REQ-007 The block SHALL have port sync, input, 1 bit: phase-realign all channels.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: divisor write request.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a divisor write.
REQ-010 The block SHALL have port cfg_ch, input, max(1,clog2(NCH)) bits: target channel of the write.
REQ-011 The block SHALL have port cfg_div, input, CNT_W bits: new divisor for the write.
REQ-012 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-013 The block SHALL have port clk_out, output, NCH bits: per-channel square wave.
REQ-014 The block SHALL have port tick, output, NCH bits: per-channel one-cycle pulse, once per clk_out period.

Function
REQ-015 Each enabled channel SHALL increment its counter every cycle and, when the counter equals its divisor D, clear the counter and toggle clk_out, so that the half-period is D+1 cycles and the full period is 2(D+1) cycles.
REQ-016 D=0 SHALL be legal and SHALL produce clk_out toggling every cycle.
REQ-017 tick[i] SHALL be high in exactly the cycle in which clk_out[i] is registered 0->1, and low otherwise.
REQ-018 A channel with ch_en[i]=0 SHALL hold its counter at 0 and clk_out[i] at 0, with tick[i]=0; after re-enable, the first toggle to 1 SHALL occur D+1 cycles later.
REQ-019 When sync=1, every counter SHALL clear to 0 and every clk_out SHALL clear to 0 on the next edge with no tick asserted; sync SHALL take priority over the terminal-count toggle.
REQ-020 A write SHALL be accepted on an edge where cfg_valid=1 and cfg_ready=1.
REQ-021 The block SHALL hold one pending write slot, and cfg_ready SHALL be 0 while the slot is occupied.
REQ-022 An accepted write with cfg_ch>=NCH SHALL be discarded, SHALL NOT occupy the slot, and SHALL pulse cfg_err for one cycle.
REQ-023 A pending divisor SHALL be applied, and the slot freed, on the first edge on which the target channel hits terminal count, is disabled, or sync=1; cfg_ready SHALL rise on the following cycle.
REQ-024 Divisor changes SHALL never shorten or lengthen a half-period already in progress; they are glitch-free.
REQ-025 A write presented while cfg_ready=0 SHALL be ignored; the source holds cfg_valid, and cfg_err SHALL NOT assert.

Reset
REQ-026 While rst=1, each divisor SHALL load from DIV_INIT, and counters, clk_out, tick, cfg_err and the pending slot SHALL clear to 0.
REQ-027 cfg_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over sync, cfg_valid and ch_en, and asserting it mid-write SHALL discard the pending write.

Structure
REQ-029 Package clkdiv_pkg SHALL hold MASTER_HZ=100000000, the default divisor constants (DIV_2HZ, DIV_1HZ, DIV_250HZ) and the default CNT_W.
REQ-030 The per-channel counter, toggle, tick and divisor register SHALL be a sub-module clkdiv_chan, instantiated NCH times by a generate loop; the shared config slot SHALL live in clkdiv_bank.

Verification
REQ-031 Run NCH=2 with DIV_INIT {3,1} and ch_en=11 after reset -> ch0 period 4 cycles, ch1 period 8 cycles, and tick on each 0->1 edge only.
REQ-032 Write ch0 cfg_div=5 mid half-period -> the current half-period completes at the old length, after which ch0 half-periods are 6 cycles, and cfg_ready drops for the interval in between.
REQ-033 Write cfg_ch=3 with NCH=2 -> cfg_err pulses for 1 cycle, cfg_ready stays 1, and no divisor changes.
REQ-034 Assert sync for 1 cycle while channels are out of phase -> all clk_out=0 and counters=0 on the next cycle, after which the rising edges are aligned.
REQ-035 Set ch_en[1]=0 for 10 cycles, then re-enable -> clk_out[1]=0 throughout, and it rises D+1 cycles after re-enable.
REQ-036 Assert rst with a write pending -> cfg_ready=0 during reset and 1 the next cycle, with divisors equal to DIV_INIT.

Source files
------------

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_pkg
//  Purpose  : Shared constants for the clock-divider bank: master clock rate,
//             default divisor values and default counter width, plus a helper
//             that sizes channel-select fields.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clkdiv_pkg;

   localparam int unsigned MASTER_HZ = 100_000_000;
   localparam int unsigned CNT_W_DEF = 32;

   // Divisor D gives a half-period of D+1 master cycles.
   localparam int unsigned DIV_2HZ   = 25_000_000;
   localparam int unsigned DIV_1HZ   = 50_000_000;
   localparam int unsigned DIV_250HZ = 200_000;

   // Width of a field that selects one of n channels (never narrower than 1).
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_chan
//  Purpose  : One divider channel: up-counter, square-wave toggle, rising-edge
//             tick and divisor register.
//  Ports    : clk       - master clock (rising edge)
//             rst       - synchronous active-high reset
//             i_en      - run enable; low holds counter and output at 0
//             i_sync    - phase realign: counter and output cleared
//             i_ld      - load i_ld_div into the divisor register
//             i_ld_div  - new divisor value
//             o_clk     - divided square wave
//             o_tick    - one-cycle pulse on each registered 0->1 of o_clk
//             o_bound   - this edge ends a half-period (safe to swap divisor)
//  Revision : 1.0  initial release
// ============================================================================
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int unsigned      CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_ld,
   input  logic [CNT_W-1:0] i_ld_div,
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_bound
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             w_tc;

   assign w_tc    = (cnt_q == div_q);
   // Any edge that restarts the half-period from a zero count is a point
   // where a new divisor cannot disturb a half-period already running.
   assign o_bound = i_sync || !i_en || w_tc;

   always_comb begin
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      div_d  = i_ld ? i_ld_div : div_q;
      if (i_sync || !i_en) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (w_tc) begin
         cnt_d  = '0;
         clk_d  = !clk_q;
         tick_d = !clk_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         div_q  <= DIV_RST;
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign o_clk  = clk_q;
   assign o_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_bank
//  Purpose  : Bank of NCH independent clock dividers sharing one master clock,
//             a common phase-realign input and a single-slot divisor write
//             port whose updates land only on half-period boundaries.
//  Ports    : masterClk - master clock (rising edge)
//             rst       - synchronous active-high reset
//             ch_en     - per-channel run enable
//             sync      - realign all channels to phase 0
//             cfg_valid - divisor write request
//             cfg_ready - write slot free
//             cfg_ch    - target channel of the write
//             cfg_div   - new divisor
//             cfg_err   - one-cycle pulse when a write targets a bad channel
//             clk_out   - per-channel square waves
//             tick      - per-channel pulse on each 0->1 of clk_out
//  Revision : 1.0  initial release
// ============================================================================
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int unsigned            NCH      = 4,
   parameter int unsigned            CNT_W    = CNT_W_DEF,
   parameter logic [NCH*CNT_W-1:0]   DIV_INIT = {CNT_W'(DIV_1HZ), CNT_W'(DIV_250HZ),
                                                 CNT_W'(DIV_1HZ), CNT_W'(DIV_2HZ)}
) (
   input  logic                        masterClk,
   input  logic                        rst,
   input  logic [NCH-1:0]              ch_en,
   input  logic                        sync,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_idx_w(NCH)-1:0]    cfg_ch,
   input  logic [CNT_W-1:0]            cfg_div,
   output logic                        cfg_err,
   output logic [NCH-1:0]              clk_out,
   output logic [NCH-1:0]              tick
);

   localparam int unsigned CH_W = ch_idx_w(NCH);

   logic             pend_vld_q, pend_vld_d;
   logic [CH_W-1:0]  pend_ch_q,  pend_ch_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_err_q,  cfg_err_d;

   logic [NCH-1:0]   w_bound;
   logic [NCH-1:0]   w_ld;
   logic             w_accept;
   logic             w_bad;
   logic             w_apply;

   // Ready is forced low during reset so nothing is accepted then.
   assign cfg_ready = !rst && !pend_vld_q;
   assign cfg_err   = cfg_err_q;
   assign w_accept  = cfg_valid && cfg_ready;
   assign w_bad     = (32'(cfg_ch) >= 32'(NCH));
   assign w_apply   = |w_ld;

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_chan
         assign w_ld[i] = pend_vld_q && (pend_ch_q == CH_W'(i)) && w_bound[i];

         clkdiv_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
         ) u_chan (
            .clk      (masterClk),
            .rst      (rst),
            .i_en     (ch_en[i]),
            .i_sync   (sync),
            .i_ld     (w_ld[i]),
            .i_ld_div (pend_div_q),
            .o_clk    (clk_out[i]),
            .o_tick   (tick[i]),
            .o_bound  (w_bound[i])
         );
      end
   endgenerate

   // A write can only be accepted while the slot is empty and the slot can
   // only be freed while it is full, so the two never collide.
   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_ch_d  = pend_ch_q;
      pend_div_d = pend_div_q;
      cfg_err_d  = 1'b0;
      if (w_apply) begin
         pend_vld_d = 1'b0;
      end
      if (w_accept) begin
         if (w_bad) begin
            cfg_err_d = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            pend_ch_d  = cfg_ch;
            pend_div_d = cfg_div;
         end
      end
   end

   always_ff @(posedge masterClk) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         pend_ch_q  <= '0;
         pend_div_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_ch_q  <= pend_ch_d;
         pend_div_q <= pend_div_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clkdiv_bank
//  Purpose  : Self-checking bench for clkdiv_bank (3 channels, 8-bit counters,
//             reset divisors 1/3/2). A cycle-level reference model tracks, per
//             channel, the output level and the number of enabled cycles left
//             before the next toggle; directed scenarios are followed by a
//             long randomized run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clkdiv_bank;

   localparam int NCH = 3;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    ch_en;
   logic          sync;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [CW-1:0] cfg_div;
   logic          cfg_err;
   logic [2:0]    clk_out;
   logic [2:0]    tick;

   always #5 clk = ~clk;

   clkdiv_bank #(
      .NCH      (NCH),
      .CNT_W    (CW),
      .DIV_INIT ({8'd2, 8'd3, 8'd1})
   ) dut (
      .masterClk (clk),
      .rst       (rst),
      .ch_en     (ch_en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int last_tick[NCH];
   int prev_tick[NCH];
   int init_div[NCH];

   // Reference model state
   int m_rem[NCH];     // enabled cycles until the next toggle
   int m_div[NCH];
   bit m_lvl[NCH];
   bit m_tick[NCH];
   bit m_pend;
   int m_pch;
   int m_pdiv;
   bit m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Predict the state after the coming rising edge from the inputs now applied.
   task automatic model_edge();
      bit rdy;
      bit bnd;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_div[i]  = init_div[i];
            m_lvl[i]  = 1'b0;
            m_tick[i] = 1'b0;
            m_rem[i]  = init_div[i] + 1;
         end
         m_pend = 1'b0;
         m_err  = 1'b0;
      end else begin
         rdy = !m_pend;
         if (m_pend) begin
            bnd = sync || !ch_en[m_pch] || (m_rem[m_pch] == 1);
            if (bnd) begin
               m_div[m_pch] = m_pdiv;
               m_pend       = 1'b0;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (sync || !ch_en[i]) begin
               m_lvl[i] = 1'b0;
               m_rem[i] = m_div[i] + 1;
            end else if (m_rem[i] == 1) begin
               m_lvl[i]  = !m_lvl[i];
               m_tick[i] = m_lvl[i];
               m_rem[i]  = m_div[i] + 1;
            end else begin
               m_rem[i] = m_rem[i] - 1;
            end
         end
         m_err = 1'b0;
         if (cfg_valid && rdy) begin
            if (int'(cfg_ch) >= NCH) begin
               m_err = 1'b1;
            end else begin
               m_pend = 1'b1;
               m_pch  = int'(cfg_ch);
               m_pdiv = int'(cfg_div);
            end
         end
      end
   endtask

   task automatic compare();
      logic [2:0] el;
      logic [2:0] et;
      for (int i = 0; i < NCH; i++) begin
         el[i] = m_lvl[i];
         et[i] = m_tick[i];
         if (tick[i]) begin
            prev_tick[i] = last_tick[i];
            last_tick[i] = cyc;
         end
      end
      chk("clk_out",   32'(clk_out),   32'(el));
      chk("tick",      32'(tick),      32'(et));
      chk("cfg_err",   32'(cfg_err),   32'(m_err));
      chk("cfg_ready", 32'(cfg_ready), 32'(!rst && !m_pend));
   endtask

   task automatic step(input logic r, input logic [2:0] en, input logic sy,
                       input logic v, input logic [1:0] ch, input logic [CW-1:0] dv);
      rst       = r;
      ch_en     = en;
      sync      = sy;
      cfg_valid = v;
      cfg_ch    = ch;
      cfg_div   = dv;
      model_edge();
      cyc++;
      @(negedge clk);
      compare();
   endtask

   task automatic run(input int n, input logic [2:0] en);
      for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 1'b0, 2'd0, '0);
   endtask

   initial begin
      int s;
      int re;
      logic [2:0] ren;
      init_div[0] = 1;
      init_div[1] = 3;
      init_div[2] = 2;
      for (int i = 0; i < NCH; i++) begin
         last_tick[i] = 0;
         prev_tick[i] = 0;
      end

      // Reset state
      step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_clk",   32'(clk_out),   32'd0);
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      chk("ready_after_rst", 32'(cfg_ready), 32'd1);

      // Default periods: ch0 D=1 -> 4 cycles, ch1 D=3 -> 8 cycles
      run(23, 3'b111);
      chk("ch0_period", 32'(last_tick[0] - prev_tick[0]), 32'd4);
      chk("ch1_period", 32'(last_tick[1] - prev_tick[1]), 32'd8);

      // Divisor write to ch0; lands only at the end of the running half-period
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd5);
      chk("ready_busy", 32'(cfg_ready), 32'd0);
      run(30, 3'b111);
      chk("ready_back",     32'(cfg_ready), 32'd1);
      chk("ch0_new_period", 32'(last_tick[0] - prev_tick[0]), 32'd12);

      // Out-of-range channel: rejected with an error pulse, slot stays free
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd3, 8'd7);
      chk("bad_err",   32'(cfg_err),   32'd1);
      chk("bad_ready", 32'(cfg_ready), 32'd1);
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      chk("bad_err_clr", 32'(cfg_err), 32'd0);
      run(20, 3'b111);
      chk("ch1_period_kept", 32'(last_tick[1] - prev_tick[1]), 32'd8);

      // Phase realign
      run(3, 3'b111);
      step(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, '0);
      s = cyc;
      chk("sync_clk",  32'(clk_out), 32'd0);
      chk("sync_tick", 32'(tick),    32'd0);
      run(8, 3'b111);
      chk("sync_ch0_rise", 32'(last_tick[0] - s), 32'd6);
      chk("sync_ch1_rise", 32'(last_tick[1] - s), 32'd4);
      chk("sync_ch2_rise", 32'(last_tick[2] - s), 32'd3);

      // Channel 1 disabled for 10 cycles, then re-enabled
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 3'b101, 1'b0, 1'b0, 2'd0, '0);
         chk("ch1_off", 32'(clk_out[1]), 32'd0);
      end
      re = cyc + 1;
      run(6, 3'b111);
      chk("reen_rise", 32'(last_tick[1]), 32'(re + 3));

      // Reset with a write pending: the write must be discarded
      step(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd0);
      step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      chk("rst_pend_ready", 32'(cfg_ready), 32'd0);
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, '0);
      chk("rst_ready_back", 32'(cfg_ready), 32'd1);
      run(24, 3'b111);
      chk("init_ch0_period", 32'(last_tick[0] - prev_tick[0]), 32'd4);
      chk("init_ch1_period", 32'(last_tick[1] - prev_tick[1]), 32'd8);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < NCH; b++) ren[b] = ($urandom_range(0, 9) != 0);
         step(($urandom_range(0, 99) == 0), ren, ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
              CW'($urandom_range(0, 6)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
